// File: rtl/fir_ctrl_pkg.sv
// fir_ctrl_pkg: shared types, sizes and constants for the FIR control sequencer.
package fir_ctrl_pkg;
   localparam int NUM_MOD      = 4;
   localparam int TAPS_PER_MOD = 10;
   localparam int DRAIN_CYC    = 2;
   localparam int NUM_COEFF    = NUM_MOD * TAPS_PER_MOD;
   localparam int SEG_LEN      = TAPS_PER_MOD + DRAIN_CYC;
   localparam int ADDR_G_W     = 6;
   localparam int ADDR_L_W     = 4;
   localparam int DATA_W       = 16;
   localparam int SEL_W        = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      UPDATE = 2'd1,
      MAC    = 2'd2
   } stateT;
endpackage

// File: rtl/fir_ctrl_fsm_coeff_addr_decode.sv
// coeff_addr_decode: splits a global coefficient address into module select and local RAM address.
module coeff_addr_decode
   import fir_ctrl_pkg::*;
(
   input  logic [ADDR_G_W-1:0] iAddr,
   output logic [SEL_W-1:0]    oSel,
   output logic [ADDR_L_W-1:0] oLocal,
   output logic                oValid
);
   logic [ADDR_L_W-1:0] baseLow;
   // Bucket by module, then subtract the bucket base on the low nibble only (the result is < TAPS_PER_MOD).
   always_comb begin
      oValid  = iAddr < ADDR_G_W'(NUM_COEFF);
      oSel    = (iAddr >= ADDR_G_W'(3 * TAPS_PER_MOD)) ? 2'd3 :
                (iAddr >= ADDR_G_W'(2 * TAPS_PER_MOD)) ? 2'd2 :
                (iAddr >= ADDR_G_W'(TAPS_PER_MOD))     ? 2'd1 : 2'd0;
      baseLow = (oSel == 2'd3) ? ADDR_L_W'(3 * TAPS_PER_MOD) :
                (oSel == 2'd2) ? ADDR_L_W'(2 * TAPS_PER_MOD) :
                (oSel == 2'd1) ? ADDR_L_W'(TAPS_PER_MOD)     : '0;
      oLocal  = iAddr[ADDR_L_W-1:0] - baseLow;
   end
endmodule

// File: rtl/fir_ctrl_fsm.sv
// fir_ctrl_fsm: routes host coefficient writes (UPDATE) and sweeps all taps per sample (MAC); optional OVERRUN_DETECT_EN adds oOverrun.
module fir_ctrl_fsm
   import fir_ctrl_pkg::*;
(
   input  logic                iClk,
   input  logic                iRsn,
   input  logic                iEnSample,
   input  logic                iCoeffUpdateFlag,
   input  logic                iCsnRam,
   input  logic                iWrnRam,
   input  logic [ADDR_G_W-1:0] iAddrRam,
   input  logic [DATA_W-1:0]   iWtDtRam,
   output logic [SEL_W-1:0]    oModuleSel,
   output logic                oCsnRam,
   output logic                oWrnRam,
   output logic [ADDR_L_W-1:0] oAddrRam,
   output logic [DATA_W-1:0]   oWtDtRam,
   output logic                oEnMul,
   output logic                oEnAddAcc,
   output logic                oAccClr,
   output logic                oDone
`ifdef OVERRUN_DETECT_EN
   ,
   output logic                oOverrun
`endif
);
   stateT               state;
   logic [ADDR_L_W-1:0] tapCnt;
   logic [ADDR_L_W-1:0] nextTap;
   logic [SEL_W-1:0]    nextMod;
   logic                segEnd;
   logic                lastCyc;
   logic [SEL_W-1:0]    decSel;
   logic [ADDR_L_W-1:0] decLocal;
   logic                decValid;

   coeff_addr_decode uDec (
      .iAddr (iAddrRam),
      .oSel  (decSel),
      .oLocal(decLocal),
      .oValid(decValid)
   );

   // oModuleSel doubles as the module counter during a sweep; tapCnt is the position inside the segment.
   always_comb begin
      segEnd  = tapCnt == ADDR_L_W'(SEG_LEN - 1);
      lastCyc = segEnd && (oModuleSel == SEL_W'(NUM_MOD - 1));
      nextTap = segEnd ? '0 : tapCnt + 1'b1;
      nextMod = segEnd ? oModuleSel + 1'b1 : oModuleSel;
   end

   // Sequencer with registered outputs; enables trail the read by the RAM and multiplier latencies.
   always_ff @(posedge iClk or negedge iRsn) begin
      if (!iRsn) begin
         state      <= IDLE;
         tapCnt     <= '0;
         oModuleSel <= '0;
         oCsnRam    <= 1'b1;
         oWrnRam    <= 1'b1;
         oAddrRam   <= '0;
         oWtDtRam   <= '0;
         oEnMul     <= 1'b0;
         oEnAddAcc  <= 1'b0;
         oAccClr    <= 1'b0;
         oDone      <= 1'b0;
`ifdef OVERRUN_DETECT_EN
         oOverrun   <= 1'b0;
`endif
      end else begin
         oAccClr <= 1'b0;
         oDone   <= 1'b0;
`ifdef OVERRUN_DETECT_EN
         if (iEnSample && state != IDLE) oOverrun <= 1'b1;
`endif
         case (state)
            IDLE: begin
               oCsnRam   <= 1'b1;
               oWrnRam   <= 1'b1;
               oEnMul    <= 1'b0;
               oEnAddAcc <= 1'b0;
               if (iCoeffUpdateFlag) begin
                  state <= UPDATE;
               end else if (iEnSample) begin
                  state      <= MAC;
                  tapCnt     <= '0;
                  oModuleSel <= '0;
                  oAddrRam   <= '0;
                  oCsnRam    <= 1'b0;
                  oAccClr    <= 1'b1;
               end
            end
            UPDATE: begin
               oEnMul    <= 1'b0;
               oEnAddAcc <= 1'b0;
               if (!iCoeffUpdateFlag) begin
                  state   <= IDLE;
                  oCsnRam <= 1'b1;
                  oWrnRam <= 1'b1;
               end else if (decValid) begin
                  oModuleSel <= decSel;
                  oAddrRam   <= decLocal;
                  oCsnRam    <= iCsnRam;
                  oWrnRam    <= iWrnRam;
                  if (!iCsnRam && !iWrnRam) oWtDtRam <= iWtDtRam;
               end else begin
                  oCsnRam <= 1'b1;
                  oWrnRam <= 1'b1;
               end
            end
            MAC: begin
               if (lastCyc) begin
                  state     <= IDLE;
                  oDone     <= 1'b1;
                  oCsnRam   <= 1'b1;
                  oEnMul    <= 1'b0;
                  oEnAddAcc <= 1'b0;
               end else begin
                  tapCnt     <= nextTap;
                  oModuleSel <= nextMod;
                  oWrnRam    <= 1'b1;
                  oCsnRam    <= nextTap >= ADDR_L_W'(TAPS_PER_MOD);
                  if (nextTap < ADDR_L_W'(TAPS_PER_MOD)) oAddrRam <= nextTap;
                  oEnMul     <= (nextTap != '0) && (nextTap <= ADDR_L_W'(TAPS_PER_MOD));
                  oEnAddAcc  <= nextTap >= ADDR_L_W'(2);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fir_ctrl_fsm.sv
// tb_fir_ctrl_fsm: scoreboard bench for fir_ctrl_fsm; honours OVERRUN_DETECT_EN.
`timescale 1ns/1ps
module tb_fir_ctrl_fsm;
   typedef struct packed {
      logic [1:0]  sel;
      logic        csn;
      logic        wrn;
      logic [3:0]  addr;
      logic [15:0] wt;
      logic        enMul;
      logic        enAdd;
      logic        accClr;
      logic        done;
   } outT;

   localparam outT RST_OUT = '{sel: 2'd0, csn: 1'b1, wrn: 1'b1, addr: 4'd0, wt: 16'd0,
                               enMul: 1'b0, enAdd: 1'b0, accClr: 1'b0, done: 1'b0};

   logic        iClk = 1'b0;
   logic        iRsn = 1'b0;
   logic        iEnSample = 1'b0;
   logic        iCoeffUpdateFlag = 1'b0;
   logic        iCsnRam = 1'b1;
   logic        iWrnRam = 1'b1;
   logic [5:0]  iAddrRam = '0;
   logic [15:0] iWtDtRam = '0;
   logic [1:0]  oModuleSel;
   logic        oCsnRam;
   logic        oWrnRam;
   logic [3:0]  oAddrRam;
   logic [15:0] oWtDtRam;
   logic        oEnMul;
   logic        oEnAddAcc;
   logic        oAccClr;
   logic        oDone;
`ifdef OVERRUN_DETECT_EN
   logic        oOverrun;
`endif

   int  checks = 0;
   int  errors = 0;
   outT expQ[$];
   outT cur;

   always #5 iClk = ~iClk;

   fir_ctrl_fsm dut (
      .iClk            (iClk),
      .iRsn            (iRsn),
      .iEnSample       (iEnSample),
      .iCoeffUpdateFlag(iCoeffUpdateFlag),
      .iCsnRam         (iCsnRam),
      .iWrnRam         (iWrnRam),
      .iAddrRam        (iAddrRam),
      .iWtDtRam        (iWtDtRam),
      .oModuleSel      (oModuleSel),
      .oCsnRam         (oCsnRam),
      .oWrnRam         (oWrnRam),
      .oAddrRam        (oAddrRam),
      .oWtDtRam        (oWtDtRam),
      .oEnMul          (oEnMul),
      .oEnAddAcc       (oEnAddAcc),
      .oAccClr         (oAccClr),
      .oDone           (oDone)
`ifdef OVERRUN_DETECT_EN
      ,
      .oOverrun        (oOverrun)
`endif
   );

   function automatic outT sampleOut();
      return {oModuleSel, oCsnRam, oWrnRam, oAddrRam, oWtDtRam, oEnMul, oEnAddAcc, oAccClr, oDone};
   endfunction

   // Address and write-enable carry no meaning while the RAM is deselected.
   function automatic outT norm(outT o, logic dc);
      outT r;
      r = o;
      if (dc) begin
         r.addr = '0;
         r.wrn  = 1'b1;
      end
      return r;
   endfunction

   // Expected outputs for sweep cycle c counted from the oAccClr cycle; c>=48 is back in IDLE.
   function automatic outT macExp(int c);
      outT e;
      int  k;
      e = cur;
      k = c % 12;
      e.wrn = 1'b1;
      e.accClr = 1'b0;
      e.done = 1'b0;
      if (c >= 48) begin
         e.sel = 2'd3;
         e.csn = 1'b1;
         e.addr = 4'd9;
         e.enMul = 1'b0;
         e.enAdd = 1'b0;
         e.done = (c == 48);
      end else begin
         e.sel = 2'(c / 12);
         e.csn = (k >= 10);
         e.addr = (k < 10) ? 4'(k) : 4'd9;
         e.enMul = (k >= 1) && (k <= 10);
         e.enAdd = (k >= 2);
         e.accClr = (c == 0);
      end
      return e;
   endfunction

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic test_reset();
      outT o, e;
      iRsn = 1'b0;
      expQ.push_back(RST_OUT);
      repeat (2) tick();
      e = expQ.pop_front();
      o = sampleOut();
      checks++;
      if (o !== e) begin errors++; $display("FAIL reset got %h want %h", o, e); end
      cur = RST_OUT;
      iRsn = 1'b1;
      expQ.push_back(cur);
      tick();
      e = expQ.pop_front();
      o = sampleOut();
      checks++;
      if (o !== e) begin errors++; $display("FAIL reset_release got %h want %h", o, e); end
   endtask

   task automatic test_coeff_load();
      outT o, e;
      int  addrs[6];
      addrs = '{0, 9, 10, 25, 39, 17};
      iCoeffUpdateFlag = 1'b1;
      expQ.push_back(cur);
      tick();
      e = expQ.pop_front();
      o = sampleOut();
      checks++;
      if (norm(o, e.csn) !== norm(e, e.csn)) begin errors++; $display("FAIL upd_entry got %h want %h", o, e); end
      for (int i = 0; i < 6; i++) begin
         if (i == 5) begin
            iCsnRam = 1'b0;
            iWrnRam = 1'b0;
            iAddrRam = 6'd40;
            iWtDtRam = 16'hDEAD;
            tick();
            checks++;
            if (oCsnRam !== 1'b1 || oWtDtRam !== cur.wt || oEnMul !== 1'b0 || oEnAddAcc !== 1'b0) begin
               errors++;
               $display("FAIL upd_addr40 got csn=%b wt=%h want csn=1 wt=%h", oCsnRam, oWtDtRam, cur.wt);
            end
         end
         iCsnRam = 1'b0;
         iWrnRam = 1'b0;
         iAddrRam = 6'(addrs[i]);
         iWtDtRam = 16'hFACE + 16'(i);
         cur.sel = 2'(addrs[i] / 10);
         cur.addr = 4'(addrs[i] % 10);
         cur.csn = 1'b0;
         cur.wrn = 1'b0;
         cur.wt = iWtDtRam;
         expQ.push_back(cur);
         tick();
         e = expQ.pop_front();
         o = sampleOut();
         checks++;
         if (o !== e) begin errors++; $display("FAIL upd_write a=%0d got %h want %h", addrs[i], o, e); end
      end
      iCsnRam = 1'b1;
      iWrnRam = 1'b1;
      iCoeffUpdateFlag = 1'b0;
      cur.csn = 1'b1;
      cur.wrn = 1'b1;
      expQ.push_back(cur);
      tick();
      e = expQ.pop_front();
      o = sampleOut();
      checks++;
      if (norm(o, e.csn) !== norm(e, e.csn)) begin errors++; $display("FAIL upd_exit got %h want %h", o, e); end
   endtask

   task automatic test_write_idle();
      outT o, e;
      iCsnRam = 1'b0;
      iWrnRam = 1'b0;
      iAddrRam = 6'd5;
      iWtDtRam = 16'h1234;
      for (int i = 0; i < 3; i++) begin
         expQ.push_back(cur);
         tick();
         e = expQ.pop_front();
         o = sampleOut();
         checks++;
         if (norm(o, e.csn) !== norm(e, e.csn)) begin errors++; $display("FAIL idle_write i=%0d got %h want %h", i, o, e); end
      end
      iCsnRam = 1'b1;
      iWrnRam = 1'b1;
      iAddrRam = '0;
   endtask

   task automatic test_single_sweep();
      outT o, e;
      int  nMul, nAdd;
      nMul = 0;
      nAdd = 0;
      for (int c = 0; c < 50; c++) begin
         iEnSample = (c == 0);
         expQ.push_back(macExp(c));
         tick();
         e = expQ.pop_front();
         o = sampleOut();
         nMul += int'(o.enMul);
         nAdd += int'(o.enAdd);
         checks++;
         if (norm(o, e.csn) !== norm(e, e.csn)) begin errors++; $display("FAIL sweep c=%0d got %h want %h", c, o, e); end
      end
      checks++;
      if (nMul != 40 || nAdd != 40) begin errors++; $display("FAIL sweep_en_count got mul=%0d add=%0d want 40/40", nMul, nAdd); end
      cur = macExp(49);
   endtask

   task automatic test_flag_and_strobe();
      outT o, e;
      for (int c = 0; c < 8; c++) begin
         iCoeffUpdateFlag = (c < 7);
         iEnSample = (c == 0);
         if (c == 1) cur.sel = 2'd0;
         expQ.push_back(cur);
         tick();
         e = expQ.pop_front();
         o = sampleOut();
         checks++;
         if (norm(o, e.csn) !== norm(e, e.csn)) begin errors++; $display("FAIL flag_strobe c=%0d got %h want %h", c, o, e); end
      end
      iEnSample = 1'b0;
   endtask

   task automatic test_flag_during_sweep();
      outT o, e;
      for (int c = 0; c < 53; c++) begin
         iEnSample = (c == 0) || (c == 31);
         iCoeffUpdateFlag = (c >= 21);
         e = (c <= 49) ? macExp(c) : macExp(49);
         if (c >= 50) e.sel = 2'd0;
         expQ.push_back(e);
         tick();
         e = expQ.pop_front();
         o = sampleOut();
         checks++;
         if (norm(o, e.csn) !== norm(e, e.csn)) begin errors++; $display("FAIL flag_sweep c=%0d got %h want %h", c, o, e); end
`ifdef OVERRUN_DETECT_EN
         checks++;
         if (oOverrun !== (c >= 31)) begin errors++; $display("FAIL overrun c=%0d got %b want %b", c, oOverrun, (c >= 31)); end
`endif
      end
      iEnSample = 1'b0;
      iCoeffUpdateFlag = 1'b0;
      cur = macExp(49);
      cur.sel = 2'd0;
      cur.addr = 4'd0;
      expQ.push_back(cur);
      tick();
      e = expQ.pop_front();
      o = sampleOut();
      checks++;
      if (norm(o, e.csn) !== norm(e, e.csn)) begin errors++; $display("FAIL flag_sweep_exit got %h want %h", o, e); end
   endtask

   task automatic test_reset_mid_sweep();
      outT o, e;
      iEnSample = 1'b1;
      tick();
      iEnSample = 1'b0;
      repeat (20) tick();
      iRsn = 1'b0;
      #2;
      expQ.push_back(RST_OUT);
      e = expQ.pop_front();
      o = sampleOut();
      checks++;
      if (o !== e) begin errors++; $display("FAIL reset_mid got %h want %h", o, e); end
`ifdef OVERRUN_DETECT_EN
      checks++;
      if (oOverrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", oOverrun); end
`endif
      tick();
      iRsn = 1'b1;
      for (int c = 0; c < 60; c++) begin
         expQ.push_back(RST_OUT);
         tick();
         e = expQ.pop_front();
         o = sampleOut();
         checks++;
         if (o !== e) begin errors++; $display("FAIL post_reset c=%0d got %h want %h", c, o, e); end
      end
      iEnSample = 1'b1;
      tick();
      iEnSample = 1'b0;
      checks++;
      if (oAccClr !== 1'b1 || oCsnRam !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_sweep got accClr=%b csn=%b want accClr=1 csn=0", oAccClr, oCsnRam);
      end
   endtask

   initial begin
      test_reset();
      test_coeff_load();
      test_write_idle();
      test_single_sweep();
      test_flag_and_strobe();
      test_flag_during_sweep();
      test_reset_mid_sweep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fir_ctrl_fsm.md
Name: fir_ctrl_fsm

Overview:
- Sequencer directly upstream of the 4-way ModuleSelector in the FIR datapath.
- Drives ModuleSelector's inputs: module select, RAM chip-select/write-enable/address/write-data, multiplier enable and add/accumulate enable.
- Two jobs: routes host coefficient writes into the four 10-tap coefficient RAMs (UPDATE mode), and, per input-sample strobe, sweeps all 40 taps module by module (MAC mode).

Parameters:
- NUM_MOD, 4, number of coefficient RAM/MAC modules.
- TAPS_PER_MOD, 10, taps stored per module RAM (addresses 0..TAPS_PER_MOD-1).
- DRAIN_CYC, 2, idle RAM cycles after each module's last read, letting delayed enables finish.

Ports:
- iClk  in  1  system clock.
- iRsn  in  1  asynchronous active-low reset.
- iEnSample  in  1  one-cycle strobe: new input sample ready.
- iCoeffUpdateFlag  in  1  level; 1 requests coefficient UPDATE mode.
- iCsnRam  in  1  host chip-select, active-low.
- iWrnRam  in  1  host write-enable, active-low.
- iAddrRam  in  6  host global coefficient address, 0..39.
- iWtDtRam  in  16  host coefficient data.
- oModuleSel  out  2  selected module, to ModuleSelector.
- oCsnRam  out  1  RAM chip-select, active-low.
- oWrnRam  out  1  RAM write-enable, active-low.
- oAddrRam  out  4  local RAM address.
- oWtDtRam  out  16  RAM write data.
- oEnMul  out  1  multiplier enable.
- oEnAddAcc  out  1  add/accumulate enable.
- oAccClr  out  1  one-cycle accumulator clear at the start of each sample sweep.
- oDone  out  1  one-cycle pulse: sample sweep complete.

Behaviour:
- Clock and reset: single clock iClk; reset iRsn is asynchronous, active-low. All outputs are registered.
- Reset values: oModuleSel=0, oCsnRam=1, oWrnRam=1, oAddrRam=0, oWtDtRam=0, oEnMul=0, oEnAddAcc=0, oAccClr=0, oDone=0. State=IDLE, counters=0.
- States:
  - IDLE: iCoeffUpdateFlag=1 -> UPDATE, priority over iEnSample in the same cycle. Else iEnSample=1 -> MAC.
  - UPDATE: exits to IDLE when iCoeffUpdateFlag=0.
  - MAC: runs to completion, then -> IDLE.
  - A flag raised during MAC takes effect after the sweep.
- UPDATE routing (latency 1 cycle): a host access at cycle n appears on the outputs at n+1.
  - oModuleSel=iAddrRam/10, oAddrRam=iAddrRam%10, oCsnRam=iCsnRam, oWrnRam=iWrnRam, oWtDtRam=iWtDtRam.
  - iAddrRam>=40: access dropped, oCsnRam=1.
  - Host accesses outside UPDATE: ignored, oCsnRam stays 1.
  - oEnMul=oEnAddAcc=0 throughout UPDATE.
- MAC sweep:
  - Entry cycle: oAccClr=1. The first read is issued on the same cycle.
  - For m=0..NUM_MOD-1, oModuleSel=m is held for TAPS_PER_MOD+DRAIN_CYC cycles (12).
  - Read cycles k=0..9: oCsnRam=0, oWrnRam=1, oAddrRam=k.
  - oEnMul is high in cycles 1..10 of the segment; oEnAddAcc is high in cycles 2..11 (RAM latency 1, multiplier latency 1).
  - Drain cycles: oCsnRam=1.
  - Total 48 cycles. oDone=1 on the cycle after module 3's last drain cycle, coincident with the return to IDLE.
- iEnSample during MAC or UPDATE: ignored (dropped).
- oWtDtRam holds its last value outside UPDATE writes.
- Reset mid-sweep: all outputs return to reset values immediately; no oDone is issued.

Optional Feature:
- Macro: OVERRUN_DETECT_EN.
- Defined:
  - Adds output oOverrun (1 bit), reset 0.
  - Set sticky when iEnSample=1 while the state is not IDLE.
  - Cleared only by iRsn.
- Undefined: the port and its logic are absent; dropped strobes go unreported.

Decomposition:
- Package fir_ctrl_pkg:
  - State encoding IDLE/UPDATE/MAC as a 2-bit typedef.
  - Constants NUM_COEFF=40, SEG_LEN=TAPS_PER_MOD+DRAIN_CYC.
  - Widths ADDR_G_W=6, ADDR_L_W=4, DATA_W=16.
- One natural sub-module: coeff_addr_decode, combinational. Maps global 6-bit address to {sel[1:0], local[3:0], valid}.

Test Plan:
- Reset: assert iRsn=0 mid-run -> every output at its reset value within the same cycle; state IDLE.
- Coefficient load: flag=1, host writes addr 0, 9, 10, 25, 39 with data 16'hFACE+i -> next cycle sel/local addr = 0/0, 0/9, 1/0, 2/5, 3/9, data matches, oCsnRam=0, oWrnRam=0. A write to addr 40 -> oCsnRam stays 1.
- Single sweep: iEnSample pulse in IDLE -> oAccClr one cycle. 40 reads with addr 0..9 per sel 0..3; oEnMul and oEnAddAcc each high 40 cycles total, lagging by 1/2 cycles. oDone exactly at entry+48.
- Simultaneous flag and strobe in IDLE -> UPDATE entered; no sweep, no oDone.
- Flag raised at sweep cycle 20 -> sweep completes, oDone pulses, then UPDATE. Strobe at cycle 30 ignored; with OVERRUN_DETECT_EN, oOverrun=1 from the next cycle.
- Host write while flag=0 -> all outputs unchanged, oCsnRam=1.
